// File: rtl/rotary_led_stepper.sv
// Steps a one-hot LED ring plus position and net counters on each rising edge of the decoder
// event, then holds off further steps for HOLDOFF cycles so that contact chatter is absorbed.
module rotary_led_stepper #(
  parameter int WIDTH   = 8,
  parameter int POS_W   = 3,
  parameter int HOLDOFF = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             r_event,
  input  logic             r_direction,
  output logic [WIDTH-1:0] led,
  output logic [POS_W-1:0] pos,
  output logic [7:0]       net,
  output logic             step,
  output logic             busy
);

  typedef enum logic [1:0] {
    WAIT_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    LOCKOUT   = 2'd2
  } state_t;

  localparam logic [15:0] CNT_LOAD = 16'(HOLDOFF - 1);

  state_t           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] led_q, led_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [7:0]       net_q, net_d;
  logic             step_q, step_d;
  logic             busy_q, busy_d;
  logic             accept;

  // A step is taken only from WAIT_HIGH, so every step needs a low seen after the last lockout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      WAIT_LOW: begin
        if (!r_event) state_d = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (r_event) begin
          accept  = 1'b1;
          state_d = LOCKOUT;
          cnt_d   = CNT_LOAD;
        end
      end
      LOCKOUT: begin
        if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
        else                state_d = r_event ? WAIT_LOW : WAIT_HIGH;
      end
      default: begin
        state_d = WAIT_LOW;
        cnt_d   = 16'd0;
      end
    endcase
  end

  always_comb begin
    led_d  = led_q;
    pos_d  = pos_q;
    net_d  = net_q;
    step_d = accept;
    busy_d = (state_d == LOCKOUT);
    if (accept) begin
      if (!r_direction) begin
        led_d = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
        pos_d = pos_q + POS_W'(1);
        net_d = net_q + 8'd1;
      end else begin
        led_d = {led_q[0], led_q[WIDTH-1:1]};
        pos_d = pos_q - POS_W'(1);
        net_d = net_q - 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= WAIT_LOW;
      cnt_q   <= 16'd0;
      led_q   <= WIDTH'(1);
      pos_q   <= '0;
      net_q   <= 8'd0;
      step_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      pos_q   <= pos_d;
      net_q   <= net_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
    end
  end

  assign led  = led_q;
  assign pos  = pos_q;
  assign net  = net_q;
  assign step = step_q;
  assign busy = busy_q;

endmodule
